// File: rtl/awgn_sample_monitor.sv
// Window statistics sink for paired AWGN samples: sum, sum of squares, peak |x|
// and outlier count, released through a one-deep result register.
module awgn_sample_monitor #(
    parameter int          LOG2_BEATS = 12,
    parameter logic [15:0] THRESH     = 16'd4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              x0,
    input  logic [15:0]              x1,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [LOG2_BEATS+17:0]   res_sum,
    output logic [LOG2_BEATS+31:0]   res_sumsq,
    output logic [15:0]              res_mean,
    output logic [16:0]              res_peak,
    output logic [LOG2_BEATS+1:0]    res_outliers
);

    localparam int SW = LOG2_BEATS + 18;
    localparam int QW = LOG2_BEATS + 32;
    localparam int OW = LOG2_BEATS + 2;
    localparam logic [LOG2_BEATS-1:0] CNT_MAX = {LOG2_BEATS{1'b1}};
    localparam logic [LOG2_BEATS-1:0] CNT_ONE = LOG2_BEATS'(1);

    function automatic logic [16:0] abs17(input logic [15:0] x);
        logic [16:0] ext;
        ext = {x[15], x};
        if (x[15]) begin
            abs17 = 17'd0 - ext;
        end else begin
            abs17 = ext;
        end
    endfunction

    // Square of a signed sample; the value never exceeds 2^30.
    function automatic logic [31:0] sq32(input logic [15:0] x);
        sq32 = $signed(x) * $signed(x);
    endfunction

    logic [LOG2_BEATS-1:0] beat_cnt_r;
    logic signed [SW-1:0]  sum_r;
    logic [QW-1:0]         sumsq_r;
    logic [16:0]           peak_r;
    logic [OW-1:0]         outl_r;

    logic                  accept_s;
    logic                  last_s;
    logic [16:0]           abs0_s;
    logic [16:0]           abs1_s;
    logic                  out0_s;
    logic                  out1_s;
    logic signed [SW-1:0]  sum_next_s;
    logic signed [SW-1:0]  mean_full_s;
    logic [QW-1:0]         sumsq_next_s;
    logic [16:0]           peak_next_s;
    logic [OW-1:0]         outl_next_s;

    assign in_ready = reset & ~clear &
                      ((beat_cnt_r != CNT_MAX) | ~res_valid | res_ready);
    assign accept_s = in_valid & in_ready;
    assign last_s   = accept_s & (beat_cnt_r == CNT_MAX);

    assign abs0_s = abs17(x0);
    assign abs1_s = abs17(x1);
    assign out0_s = abs0_s > {1'b0, THRESH};
    assign out1_s = abs1_s > {1'b0, THRESH};

    assign sum_next_s   = sum_r + $signed({{(SW-16){x0[15]}}, x0})
                                + $signed({{(SW-16){x1[15]}}, x1});
    assign sumsq_next_s = sumsq_r + QW'(sq32(x0)) + QW'(sq32(x1));
    assign outl_next_s  = outl_r + OW'(out0_s) + OW'(out1_s);
    assign mean_full_s  = sum_next_s >>> (LOG2_BEATS + 1);

    // Running peak including the current beat.
    always_comb begin
        peak_next_s = peak_r;
        if (abs0_s > peak_next_s) begin
            peak_next_s = abs0_s;
        end else begin
            peak_next_s = peak_next_s;
        end
        if (abs1_s > peak_next_s) begin
            peak_next_s = abs1_s;
        end else begin
            peak_next_s = peak_next_s;
        end
    end

    // Beat counter, wraps at the end of each window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_r <= '0;
        end else if (clear) begin
            beat_cnt_r <= '0;
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
        end
    end

    // Accumulators restart on the last beat so the next window has no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r   <= '0;
            sumsq_r <= '0;
            peak_r  <= 17'd0;
            outl_r  <= '0;
        end else if (clear || last_s) begin
            sum_r   <= '0;
            sumsq_r <= '0;
            peak_r  <= 17'd0;
            outl_r  <= '0;
        end else if (accept_s) begin
            sum_r   <= sum_next_s;
            sumsq_r <= sumsq_next_s;
            peak_r  <= peak_next_s;
            outl_r  <= outl_next_s;
        end
    end

    // Result register: loads only on the last beat, untouched by clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_sum      <= '0;
            res_sumsq    <= '0;
            res_mean     <= 16'd0;
            res_peak     <= 17'd0;
            res_outliers <= '0;
        end else if (last_s) begin
            res_sum      <= sum_next_s;
            res_sumsq    <= sumsq_next_s;
            res_mean     <= mean_full_s[15:0];
            res_peak     <= peak_next_s;
            res_outliers <= outl_next_s;
        end
    end

    // Result valid flag: a new load wins over a simultaneous read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
        end else if (last_s) begin
            res_valid <= 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_awgn_sample_monitor.sv
// Bench for awgn_sample_monitor (4-beat windows): fixed vectors, back-pressure,
// clear and reset sequences, then random traffic against a window-level model.
module tb_awgn_sample_monitor;
    localparam int LB = 2;
    localparam int SW = LB + 18;
    localparam int QW = LB + 32;
    localparam int OW = LB + 2;
    localparam int BEATS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   x0 = 16'd0;
    logic [15:0]   x1 = 16'd0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [SW-1:0] res_sum;
    logic [QW-1:0] res_sumsq;
    logic [15:0]   res_mean;
    logic [16:0]   res_peak;
    logic [OW-1:0] res_outliers;

    awgn_sample_monitor #(.LOG2_BEATS(LB), .THRESH(16'd4096)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .x0(x0), .x1(x1), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_sumsq(res_sumsq),
        .res_mean(res_mean), .res_peak(res_peak), .res_outliers(res_outliers)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sum; longint sumsq; longint mean; longint peak; longint outl;
    } res_t;

    typedef struct {
        logic [3:0][15:0] x0; logic [3:0][15:0] x1; res_t r;
    } vec_t;

    int     total = 0;
    int     bad = 0;
    res_t   exp_q[$];
    longint samples[$];
    int     m_beats = 0;

    function automatic void cmp(string name, longint act, longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic void model_clear();
        samples.delete();
        m_beats = 0;
    endfunction

    // Window statistics computed from the stored samples once the window is full.
    function automatic void model_accept(logic [15:0] a, logic [15:0] b);
        res_t r;
        samples.push_back(longint'($signed(a)));
        samples.push_back(longint'($signed(b)));
        m_beats++;
        if (m_beats == BEATS) begin
            r = '{0, 0, 0, 0, 0};
            foreach (samples[i]) begin
                longint mag;
                mag = (samples[i] < 0) ? -samples[i] : samples[i];
                r.sum   += samples[i];
                r.sumsq += samples[i] * samples[i];
                if (mag > r.peak) r.peak = mag;
                if (mag > 4096) r.outl++;
            end
            r.mean = (r.sum < 0) ? -((-r.sum + 7) / 8) : r.sum / 8;
            exp_q.push_back(r);
            model_clear();
        end
    endfunction

    task automatic check_res(string tag, res_t e);
        cmp({tag, ".sum"},   longint'($signed(res_sum)), e.sum);
        cmp({tag, ".sumsq"}, longint'(res_sumsq), e.sumsq);
        cmp({tag, ".mean"},  longint'($signed(res_mean)), e.mean);
        cmp({tag, ".peak"},  longint'(res_peak), e.peak);
        cmp({tag, ".outl"},  longint'(res_outliers), e.outl);
    endtask

    // One clock: observe at negedge, update the model, return posedge+1.
    task automatic tick(output bit took);
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !clear && (m_beats != BEATS - 1 || exp_q.size() == 0 || res_ready);
        cmp("in_ready", longint'(in_ready), longint'(exp_rdy));
        cmp("res_valid", longint'(res_valid), longint'(exp_q.size() != 0));
        if (res_valid && exp_q.size() != 0) begin
            check_res("res", exp_q[0]);
            if (res_ready) void'(exp_q.pop_front());
        end
        took = in_valid && in_ready;
        if (clear) model_clear();
        else if (took) model_accept(x0, x1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(logic [15:0] a, logic [15:0] b);
        bit t;
        x0 = a; x1 = b; in_valid = 1'b1;
        t = 1'b0;
        for (int n = 0; n < 50 && !t; n++) tick(t);
        cmp("send_taken", longint'(t), 64'sd1);
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'd4096;
            3: v = 16'd4097;
            4: v = 16'hF000;
            5: v = 16'hEFFF;
            6: v = 16'($urandom);
            default: v = 16'($urandom_range(0, 128)) - 16'd64;
        endcase
        return v;
    endfunction

    task automatic send_random(int n);
        for (int i = 0; i < n; i++) send_beat(rnd16(), rnd16());
    endtask

    vec_t vt[3];

    task automatic run_vec(int i);
        res_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) send_beat(vt[i].x0[b], vt[i].x1[b]);
        cmp("vec.valid", longint'(res_valid), 64'sd1);
        check_res($sformatf("vec%0d", i), vt[i].r);
    endtask

    initial begin
        bit t;
        vt[0].x0 = {4{16'h0800}}; vt[0].x1 = {4{16'h0800}};
        vt[0].r  = '{16384, 33554432, 2048, 2048, 0};
        vt[1].x0 = {4{16'h8000}}; vt[1].x1 = {4{16'h8000}};
        vt[1].r  = '{-262144, 64'sd8589934592, -32768, 32768, 8};
        vt[2].x0 = {16'd0, 16'd7, 16'hFFFF, 16'd3};
        vt[2].x1 = {16'hFFFD, 16'hFFFE, 16'h0000, 16'hFFFB};
        vt[2].r  = '{-1, 97, -1, 7, 0};

        repeat (2) @(posedge clk);
        #1;
        cmp("rst.in_ready", longint'(in_ready), 64'sd0);
        cmp("rst.res_valid", longint'(res_valid), 64'sd0);
        check_res("rst", '{0, 0, 0, 0, 0});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) run_vec(i);
        tick(t);

        // Back-pressure: first result held, beat 8 stalls until it is read.
        res_ready = 1'b0;
        send_random(7);
        x0 = rnd16(); x1 = rnd16(); in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(t);
            cmp("bp.stall", longint'(t), 64'sd0);
        end
        res_ready = 1'b1;
        tick(t);
        cmp("bp.take", longint'(t), 64'sd1);
        in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) tick(t);
        res_ready = 1'b1;
        tick(t);

        // Clear mid-window with a pending result that must survive.
        res_ready = 1'b0;
        send_random(4);
        send_random(2);
        clear = 1'b1;
        tick(t);
        clear = 1'b0;
        repeat (2) tick(t);
        run_vec(0);
        tick(t);

        // Random traffic.
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || t) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x0 = rnd16(); x1 = rnd16();
            end
            res_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 60) == 0);
            tick(t);
        end
        in_valid = 1'b0; clear = 1'b0; res_ready = 1'b1;
        repeat (3) tick(t);

        // Asynchronous reset mid-window with a pending result.
        res_ready = 1'b0;
        send_random(5);
        #3;
        reset = 1'b0;
        #1;
        cmp("arst.in_ready", longint'(in_ready), 64'sd0);
        cmp("arst.res_valid", longint'(res_valid), 64'sd0);
        check_res("arst", '{0, 0, 0, 0, 0});
        exp_q.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_vec(2);
        tick(t);
        cmp("drain.empty", longint'(exp_q.size()), 64'sd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/awgn_sample_monitor.md
Name: awgn_sample_monitor

Overview:
Streaming sink for the Box-Muller AWGN generator. It consumes the generator's paired output samples x0/x1 over a valid/ready handshake and accumulates window statistics in hardware: sum, sum of squares, peak magnitude and an outlier count. Results are released at the end of each window through a one-deep result register with its own valid/ready handshake. This lets silicon/FPGA builds check noise quality (mean ≈ 0, variance, tails) without dumping samples to files.

Parameters:
LOG2_BEATS, 12, window length = 2^LOG2_BEATS input beats = 2^(LOG2_BEATS+1) samples
THRESH, 16'd4096, outlier threshold on |sample|, unsigned, compared as |x| > THRESH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous: zero accumulators and beat counter
in_valid  input  1  x0/x1 beat valid
in_ready  output  1  monitor accepts beat this cycle
x0  input  16  AWGN sample 0, signed two's complement
x1  input  16  AWGN sample 1, signed two's complement
res_valid  output  1  result register full
res_ready  input  1  downstream takes result
res_sum  output  LOG2_BEATS+18  signed sum of all window samples
res_sumsq  output  LOG2_BEATS+32  unsigned sum of squares
res_mean  output  16  res_sum >>> (LOG2_BEATS+1), arithmetic shift (floor)
res_peak  output  17  max |sample| in window, unsigned (|-32768| = 32768)
res_outliers  output  LOG2_BEATS+2  count of samples with |x| > THRESH

Behaviour:
- Reset (reset=0, async): beat_cnt, all accumulators, all res_* outputs = 0; res_valid=0; in_ready=0 during reset; in_ready=1 from first cycle after release.
- Beat accepted when in_valid & in_ready on a rising edge. Both x0 and x1 are folded in the same cycle.
- Per beat: sum += sx0+sx1 (sign-extended); sumsq += x0*x0 + x1*x1 (signed multiply, unsigned 31-bit result each); peak = max(peak, |x0|, |x1|), abs computed in 17 bits; outliers += (|x0|>THRESH) + (|x1|>THRESH).
- Widths guarantee no overflow: a full window of -32768 gives sum = -2^(LOG2_BEATS+16), sumsq = 2^(LOG2_BEATS+31).
- beat_cnt counts 0..2^LOG2_BEATS-1 and wraps. The beat accepted with beat_cnt = max is the last beat.
- On the last beat, the final values (including that beat) load into the res_* registers on the same edge. res_valid=1 the next cycle, so latency is 1 cycle from the last beat. Accumulators and peak restart at 0 on that same edge, with no gap cycle.
- in_ready = reset_n & !clear & (beat_cnt != max | !res_valid | res_ready).
  - Non-last beats are never stalled.
  - The last beat stalls only while the previous result is still unread.
- Result handshake: res_valid & res_ready clears res_valid. If a new result loads in that same cycle, res_valid stays 1 with the new values. res_* values are stable while res_valid=1 and res_ready=0.
- clear: zeros beat_cnt, accumulators, peak and outliers. It has no effect on the pending result register or res_valid. in_ready=0 while clear=1, so no beat is lost ambiguously.
- x0/x1 are ignored when in_valid=0. A beat with in_ready=0 is not consumed; the source holds it.
- Reset mid-window discards the partial window and any pending result.
- Registers: beat counter, 4 accumulators, 6 result registers. Single always block per register group. Multipliers combinational into the accumulator adder, no pipelining required.

Test Plan:
- LOG2_BEATS=2, THRESH=4096; 4 beats x0=x1=16'h0800, res_ready=1 → one cycle after 4th beat res_valid=1, res_sum=16384, res_sumsq=33554432, res_mean=2048, res_peak=2048, res_outliers=0.
- LOG2_BEATS=2; 4 beats x0=x1=16'h8000 → res_sum=-262144, res_sumsq=2^33, res_mean=-32768 (16'h8000), res_peak=32768, res_outliers=8.
- Beats (x0,x1)=(3,-5),(-1,0),(7,-2),(0,-3) → res_sum=-1, res_mean=-1 (floor), res_sumsq=97, res_peak=7, res_outliers=0.
- Back-pressure: hold res_ready=0, stream 8 beats continuously → beats 1-7 accepted; in_ready=0 on beat 8 until res_ready pulses. First result is held unchanged. Second result appears the cycle after beat 8 is taken.
- clear asserted after 2 beats, then 4 beats of 16'h0800 → result matches scenario 1. A pending result present before clear is unaffected.
- Assert reset low asynchronously mid-window with res_valid=1 → res_valid and all outputs go to 0 immediately. After release, a fresh 4-beat window gives correct values.
